// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the EXE->MEM control bundle and the skid-buffer state encoding.
package pipe_pkg;

  localparam int EXE_MEM_CTRL_W = 3;

  // Packed MSB-first, so the bundle reads as {wb_en, mem_r_en, mem_w_en}.
  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } exe_mem_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: MAIN drives the output and SKID catches the beat accepted while MAIN stalls.
// Handshake: a beat moves when valid & ready are both high on a rising edge; in_ready is registered.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output skid_state_e  state_o
);

  skid_state_e state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = (state_q != ST_EMPTY) & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Payload registers keep their contents; only the occupancy is cleared.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_HALF;
            main_d  = in_data;
          end
        end
        ST_HALF: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_HALF;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    in_ready = in_ready_q;
    out_data = main_q;
    state_o  = state_q;
  end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: packs the beat into a skid buffer, gates control bits with
// out_valid and counts stalled cycles with a saturating counter.
module exe_mem_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic [DATA_W-1:0]      pc_in,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      st_val_in,
  input  logic [REG_ADDR_W-1:0]  dest_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   wb_en,
  output logic                   mem_r_en,
  output logic                   mem_w_en,
  output logic [DATA_W-1:0]      pc,
  output logic [DATA_W-1:0]      alu_result,
  output logic [DATA_W-1:0]      st_val,
  output logic [REG_ADDR_W-1:0]  dest,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PAYLOAD_W = EXE_MEM_CTRL_W + 3 * DATA_W + REG_ADDR_W;

  exe_mem_ctrl_t          ctrl_in, head_ctrl;
  logic [PAYLOAD_W-1:0]   payload_in, payload_out;
  skid_state_e            buf_state;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    ctrl_in.wb_en    = wb_en_in;
    ctrl_in.mem_r_en = mem_r_en_in;
    ctrl_in.mem_w_en = mem_w_en_in;
    payload_in       = {ctrl_in, pc_in, alu_result_in, st_val_in, dest_in};
  end

  pipe_skid_buf #(.W(PAYLOAD_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (payload_in),
    .out_ready(out_ready),
    .out_data (payload_out),
    .state_o  (buf_state)
  );

  always_comb begin
    out_valid = (buf_state != ST_EMPTY);
    {head_ctrl, pc, alu_result, st_val, dest} = payload_out;
    wb_en    = out_valid & head_ctrl.wb_en;
    mem_r_en = out_valid & head_ctrl.mem_r_en;
    mem_w_en = out_valid & head_ctrl.mem_w_en;
  end

  // Counts every cycle MEM holds a valid head, flush cycles included; only rst clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Directed bench for exe_mem_pipe_reg: streaming, stall/skid, flush, reset and counter saturation.
module tb_exe_mem_pipe_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default widths)
  logic        flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic        wb_en, mem_r_en, mem_w_en;
  logic [31:0] pc_in = '0, alu_result_in = '0, st_val_in = '0;
  logic [31:0] pc, alu_result, st_val;
  logic [4:0]  dest_in = '0, dest;
  logic [15:0] stall_cnt;

  exe_mem_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .pc(pc), .alu_result(alu_result), .st_val(st_val), .dest(dest),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance for saturation
  logic        s_flush = 1'b0, s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0;
  logic        s_wb_en, s_mem_r_en, s_mem_w_en;
  logic [31:0] s_pc_in = '0, s_pc, s_alu_result, s_st_val;
  logic [4:0]  s_dest;
  logic [3:0]  s_stall_cnt;

  exe_mem_pipe_reg #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .wb_en_in(1'b1), .mem_r_en_in(1'b0), .mem_w_en_in(1'b0),
    .pc_in(s_pc_in), .alu_result_in(32'h0), .st_val_in(32'h0), .dest_in(5'd0),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .wb_en(s_wb_en), .mem_r_en(s_mem_r_en),
    .mem_w_en(s_mem_w_en), .pc(s_pc), .alu_result(s_alu_result), .st_val(s_st_val), .dest(s_dest),
    .stall_cnt(s_stall_cnt)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p, input logic wb, input logic mw);
    in_valid      = v;
    pc_in         = p;
    alu_result_in = p + 32'h1000;
    st_val_in     = ~p;
    dest_in       = p[6:2];
    wb_en_in      = wb;
    mem_r_en_in   = 1'b0;
    mem_w_en_in   = mw;
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    step(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ctrl", {wb_en, mem_r_en, mem_w_en}, 0);
    check("rst_pc", pc, 0);
    check("rst_alu", alu_result, 0);
    check("rst_st_val", st_val, 0);
    check("rst_dest", dest, 0);
    check("rst_stall", stall_cnt, 0);
    rst = 1'b0;

    // 2: streaming with 1-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    check("s_valid0", out_valid, 1);
    check("s_pc0", pc, 32'h100);
    check("s_rdy0", in_ready, 1);
    drive(1'b1, 32'h104, 1'b1, 1'b0);
    step();
    check("s_pc1", pc, 32'h104);
    check("s_wb1", wb_en, 1);
    check("s_alu1", alu_result, 32'h1104);
    check("s_st1", st_val, 32'hFFFF_FEFB);
    check("s_dest1", dest, 5'd1);
    check("s_rdy1", in_ready, 1);
    drive(1'b1, 32'h108, 1'b0, 1'b0);
    step();
    check("s_pc2", pc, 32'h108);
    check("s_wb2", wb_en, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("s_drain", out_valid, 0);
    check("s_stall", stall_cnt, 0);

    // 3: skid into FULL, then in-order drain
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    step();
    check("k_pc_half", pc, 32'h200);
    out_ready = 1'b0;
    drive(1'b1, 32'h204, 1'b0, 1'b0);
    step();
    check("k_pc_full", pc, 32'h200);
    check("k_rdy_full", in_ready, 0);
    check("k_stall1", stall_cnt, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("k_pc_hold", pc, 32'h200);
    check("k_stall2", stall_cnt, 2);
    out_ready = 1'b1;
    step();
    check("k_pc_second", pc, 32'h204);
    check("k_rdy_half", in_ready, 1);
    check("k_stall_kept", stall_cnt, 2);
    step();
    check("k_empty", out_valid, 0);

    // 4: flush from FULL holding stores, with a beat presented
    out_ready = 1'b0;
    drive(1'b1, 32'h280, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h284, 1'b0, 1'b1);
    step();
    check("f_mw_full", mem_w_en, 1);
    check("f_rdy_full", in_ready, 0);
    check("f_stall3", stall_cnt, 3);
    flush = 1'b1;
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("f_valid", out_valid, 0);
    check("f_mw", mem_w_en, 0);
    check("f_rdy", in_ready, 1);
    check("f_stall4", stall_cnt, 4);
    out_ready = 1'b1;
    step();
    check("f_no_300", out_valid, 0);

    // Flush from HALF while in_ready=1: presented beat must be dropped
    drive(1'b1, 32'h310, 1'b1, 1'b0);
    step();
    check("fh_pc", pc, 32'h310);
    flush = 1'b1;
    drive(1'b1, 32'h314, 1'b1, 1'b0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("fh_valid", out_valid, 0);
    check("fh_wb", wb_en, 0);
    step();
    check("fh_no_314", out_valid, 0);
    check("fh_stall", stall_cnt, 4);

    // 6: reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h404, 1'b0, 1'b0);
    step();
    check("r_rdy_full", in_ready, 0);
    check("r_stall5", stall_cnt, 5);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("r_valid", out_valid, 0);
    check("r_rdy", in_ready, 1);
    check("r_stall", stall_cnt, 0);
    check("r_pc", pc, 0);
    out_ready = 1'b1;
    step(2);
    check("r_no_emit", out_valid, 0);

    // 5: 4-bit stall counter saturates at 15
    s_in_valid = 1'b1;
    s_pc_in    = 32'h500;
    step();
    s_in_valid = 1'b0;
    check("c_loaded", s_stall_cnt, 0);
    check("c_wb", s_wb_en, 1);
    step(14);
    check("c_14", s_stall_cnt, 14);
    step();
    check("c_15", s_stall_cnt, 15);
    step(5);
    check("c_sat", s_stall_cnt, 15);
    check("c_pc_hold", s_pc, 32'h500);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
